// File: rtl/clint_pkg.sv
// Shared CLINT constants: register offsets, time width, compare reset value
// and the byte-lane merge helper used by every writable register.
package clint_pkg;

  localparam int TIME_WIDTH = 64;

  localparam logic [31:0] CLINT_BASE      = 32'h0020_0000;
  localparam logic [31:0] MSIP_OFFSET     = 32'h0000_0000;
  localparam logic [31:0] MTIMECMP_OFFSET = 32'h0000_4000;
  localparam logic [31:0] MTIME_OFFSET    = 32'h0000_bff8;

  localparam logic [TIME_WIDTH-1:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

  // Replace only the byte lanes selected by byteEnable, keep the rest.
  function automatic logic [31:0] mergeBytes(
    input logic [31:0] oldWord,
    input logic [31:0] newWord,
    input logic [3:0]  byteEnable
  );
    logic [31:0] merged;
    merged = oldWord;
    for (int b = 0; b < 4; b++) begin
      if (byteEnable[b]) merged[8*b +: 8] = newWord[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/clint_cmp_channel.sv
// One hart's mtimecmp register with byte-enabled writes and the registered
// mtime >= mtimecmp timer interrupt.
module clint_cmp_channel
  import clint_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  writeLow,
  input  logic                  writeHigh,
  input  logic [3:0]            writeByteEnable,
  input  logic [31:0]           writeData,
  input  logic [TIME_WIDTH-1:0] mtime,
  output logic [31:0]           cmpLow,
  output logic [31:0]           cmpHigh,
  output logic                  timerInterrupt
);

  logic [TIME_WIDTH-1:0] mtimecmp;

  // Compare register: each word updates only on its own byte lanes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mtimecmp <= MTIMECMP_RESET;
    end else begin
      if (writeLow)  mtimecmp[31:0]  <= mergeBytes(mtimecmp[31:0], writeData, writeByteEnable);
      if (writeHigh) mtimecmp[63:32] <= mergeBytes(mtimecmp[63:32], writeData, writeByteEnable);
    end
  end

  // Interrupt is registered from current register values, so it trails both
  // mtime reaching the compare value and a compare write by one cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) timerInterrupt <= 1'b0;
    else       timerInterrupt <= (mtime >= mtimecmp);
  end

  assign cmpLow  = mtimecmp[31:0];
  assign cmpHigh = mtimecmp[63:32];

endmodule

// File: rtl/clint_timer.sv
// Core-local interruptor: prescaled 64-bit mtime, per-hart mtimecmp channels
// and msip bits behind a simple word-addressed register bus.
module clint_timer
  import clint_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 32,
  parameter int NUM_HARTS    = 2,
  parameter int PRESCALE     = 1,
  parameter logic [ADDRESS_BITS-1:0] MSIP_BASE     = ADDRESS_BITS'(CLINT_BASE + MSIP_OFFSET),
  parameter logic [ADDRESS_BITS-1:0] MTIMECMP_BASE = ADDRESS_BITS'(CLINT_BASE + MTIMECMP_OFFSET),
  parameter logic [ADDRESS_BITS-1:0] MTIME_ADDR    = ADDRESS_BITS'(CLINT_BASE + MTIME_OFFSET)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    readEnable,
  input  logic                    writeEnable,
  input  logic [DATA_WIDTH/8-1:0] writeByteEnable,
  input  logic [ADDRESS_BITS-1:0] address,
  input  logic [DATA_WIDTH-1:0]   writeData,
  output logic [DATA_WIDTH-1:0]   readData,
  output logic [NUM_HARTS-1:0]    timer_interrupt,
  output logic [NUM_HARTS-1:0]    software_interrupt
);

  localparam logic [15:0] PRESCALE_LAST = 16'(PRESCALE - 1);

  logic [TIME_WIDTH-1:0] mtime;
  logic [15:0]           prescaleCount;
  logic                  tick;
  logic                  mtimeLowHit;
  logic                  mtimeHighHit;
  logic                  mtimeWrite;
  logic [NUM_HARTS-1:0]  msip;
  logic [NUM_HARTS-1:0]  msipHit;
  logic [NUM_HARTS-1:0]  cmpLowHit;
  logic [NUM_HARTS-1:0]  cmpHighHit;
  logic [31:0]           cmpLowWord  [NUM_HARTS];
  logic [31:0]           cmpHighWord [NUM_HARTS];
  logic [DATA_WIDTH-1:0] readMux;

  // Address decode for every mapped word; anything else is a silent hole.
  always_comb begin
    mtimeLowHit  = (address == MTIME_ADDR);
    mtimeHighHit = (address == ADDRESS_BITS'(MTIME_ADDR + 4));
    msipHit      = '0;
    cmpLowHit    = '0;
    cmpHighHit   = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      msipHit[h]    = (address == ADDRESS_BITS'(MSIP_BASE + 4*h));
      cmpLowHit[h]  = (address == ADDRESS_BITS'(MTIMECMP_BASE + 8*h));
      cmpHighHit[h] = (address == ADDRESS_BITS'(MTIMECMP_BASE + 8*h + 4));
    end
  end

  assign tick       = (prescaleCount == PRESCALE_LAST);
  assign mtimeWrite = writeEnable && (mtimeLowHit || mtimeHighHit);

  // Time base: a software write owns the whole counter for that cycle and
  // restarts the prescaler; otherwise count prescaled ticks, wrapping at 2^64.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mtime         <= '0;
      prescaleCount <= '0;
    end else if (mtimeWrite) begin
      prescaleCount <= '0;
      if (mtimeLowHit)  mtime[31:0]  <= mergeBytes(mtime[31:0], writeData, writeByteEnable);
      if (mtimeHighHit) mtime[63:32] <= mergeBytes(mtime[63:32], writeData, writeByteEnable);
    end else if (tick) begin
      mtime         <= mtime + TIME_WIDTH'(1);
      prescaleCount <= '0;
    end else begin
      prescaleCount <= prescaleCount + 16'd1;
    end
  end

  // Software interrupt bits; only byte lane 0 carries the msip bit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      msip <= '0;
    end else begin
      for (int h = 0; h < NUM_HARTS; h++) begin
        if (writeEnable && msipHit[h] && writeByteEnable[0]) msip[h] <= writeData[0];
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_HARTS; g++) begin : gChannel
      clint_cmp_channel channel (
        .clock           (clock),
        .reset           (reset),
        .writeLow        (writeEnable && cmpLowHit[g]),
        .writeHigh       (writeEnable && cmpHighHit[g]),
        .writeByteEnable (writeByteEnable),
        .writeData       (writeData),
        .mtime           (mtime),
        .cmpLow          (cmpLowWord[g]),
        .cmpHigh         (cmpHighWord[g]),
        .timerInterrupt  (timer_interrupt[g])
      );
    end
  endgenerate

  // Read selection from pre-write register contents; holes read as zero.
  always_comb begin
    readMux = '0;
    if (mtimeLowHit)  readMux = mtime[31:0];
    if (mtimeHighHit) readMux = mtime[63:32];
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (msipHit[h])    readMux = DATA_WIDTH'(msip[h]);
      if (cmpLowHit[h])  readMux = cmpLowWord[h];
      if (cmpHighHit[h]) readMux = cmpHighWord[h];
    end
  end

  // Registered read port that holds its last value between reads.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)           readData <= '0;
    else if (readEnable) readData <= readMux;
  end

  assign software_interrupt = msip;

endmodule

// File: tb/tb_clint_timer.sv
// Directed self-checking bench for clint_timer: one instance at PRESCALE=1
// drives most scenarios, a second at PRESCALE=4 checks the prescaled time base.
module tb_clint_timer;

  localparam logic [31:0] MSIP_BASE     = 32'h0020_0000;
  localparam logic [31:0] MTIMECMP_BASE = 32'h0020_4000;
  localparam logic [31:0] MTIME_ADDR    = 32'h0020_bff8;

  logic        clock = 1'b0;
  logic        reset;
  logic        readEnable;
  logic        writeEnable;
  logic [3:0]  writeByteEnable;
  logic [31:0] address;
  logic [31:0] writeData;
  logic [31:0] readData;
  logic [1:0]  timerInterrupt;
  logic [1:0]  softwareInterrupt;

  logic        resetPre;
  logic        readEnablePre;
  logic [31:0] addressPre;
  logic [31:0] readDataPre;
  logic [1:0]  timerPre;
  logic [1:0]  softPre;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  clint_timer #(.PRESCALE(1)) dut (
    .clock              (clock),
    .reset              (reset),
    .readEnable         (readEnable),
    .writeEnable        (writeEnable),
    .writeByteEnable    (writeByteEnable),
    .address            (address),
    .writeData          (writeData),
    .readData           (readData),
    .timer_interrupt    (timerInterrupt),
    .software_interrupt (softwareInterrupt)
  );

  clint_timer #(.PRESCALE(4)) dutPre (
    .clock              (clock),
    .reset              (resetPre),
    .readEnable         (readEnablePre),
    .writeEnable        (1'b0),
    .writeByteEnable    (4'h0),
    .address            (addressPre),
    .writeData          (32'h0),
    .readData           (readDataPre),
    .timer_interrupt    (timerPre),
    .software_interrupt (softPre)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One bus cycle: drive at posedge+1, let the next edge sample, return at posedge+1.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] be);
    readEnable      = rd;
    writeEnable     = wr;
    address         = addr;
    writeData       = data;
    writeByteEnable = be;
    @(posedge clock);
    #1;
    readEnable      = 1'b0;
    writeEnable     = 1'b0;
    address         = 32'h0;
    writeData       = 32'h0;
    writeByteEnable = 4'h0;
  endtask

  initial begin
    reset           = 1'b1;
    resetPre        = 1'b1;
    readEnable      = 1'b0;
    writeEnable     = 1'b0;
    writeByteEnable = 4'h0;
    address         = 32'h0;
    writeData       = 32'h0;
    readEnablePre   = 1'b0;
    addressPre      = 32'h0;

    // Reset held for three cycles
    repeat (3) @(posedge clock);
    #1;
    checkOutput("resetReadData", 64'(readData), 64'h0);
    checkOutput("resetTimerIrq", 64'(timerInterrupt), 64'h0);
    checkOutput("resetSoftIrq", 64'(softwareInterrupt), 64'h0);
    checkOutput("resetMtime", dut.mtime, 64'h0);
    reset = 1'b0;

    // Scenario 1: first edge after release is tick 1, ten more cycles -> mtime 11
    repeat (11) @(posedge clock);
    #1;
    applyStimulus(1'b1, 1'b0, MTIME_ADDR, 32'h0, 4'h0);
    checkOutput("s1MtimeLow", 64'(readData), 64'd11);
    @(posedge clock);
    #1;
    checkOutput("s1ReadHold", 64'(readData), 64'd11);

    // Scenario 2: PRESCALE=4, prescaler cycles 1,2,3,0 and mtime steps every 4 edges
    resetPre = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clock);
      #1;
      checkOutput("s2Prescale", 64'(dutPre.prescaleCount), 64'(i % 4));
    end
    checkOutput("s2MtimeAt8", dutPre.mtime, 64'd2);
    repeat (32) @(posedge clock);
    #1;
    readEnablePre = 1'b1;
    addressPre    = MTIME_ADDR;
    @(posedge clock);
    #1;
    readEnablePre = 1'b0;
    checkOutput("s2MtimeLow40", 64'(readDataPre), 64'd10);

    // Scenario 3: mtime restarted at 0, mtimecmp[1] = 20
    applyStimulus(1'b0, 1'b1, MTIME_ADDR, 32'h0, 4'hF);
    applyStimulus(1'b0, 1'b1, MTIMECMP_BASE + 32'd8, 32'd20, 4'hF);
    applyStimulus(1'b0, 1'b1, MTIMECMP_BASE + 32'd12, 32'h0, 4'hF);
    checkOutput("s3MtimeAfterWrites", dut.mtime, 64'd2);
    repeat (18) @(posedge clock);
    #1;
    checkOutput("s3IrqBeforeReach", 64'(timerInterrupt), 64'b00);
    @(posedge clock);
    #1;
    checkOutput("s3IrqRise", 64'(timerInterrupt), 64'b10);
    applyStimulus(1'b0, 1'b1, MTIMECMP_BASE + 32'd12, 32'h1, 4'hF);
    checkOutput("s3IrqStillHigh", 64'(timerInterrupt), 64'b10);
    @(posedge clock);
    #1;
    checkOutput("s3IrqFall", 64'(timerInterrupt), 64'b00);

    // Scenario 4: all-ones mtime wraps to zero on the next tick
    applyStimulus(1'b0, 1'b1, MTIME_ADDR, 32'hFFFF_FFFF, 4'hF);
    applyStimulus(1'b0, 1'b1, MTIME_ADDR + 32'd4, 32'hFFFF_FFFF, 4'hF);
    checkOutput("s4AllOnes", dut.mtime, 64'hFFFF_FFFF_FFFF_FFFF);
    @(posedge clock);
    #1;
    applyStimulus(1'b1, 1'b0, MTIME_ADDR, 32'h0, 4'h0);
    checkOutput("s4WrapLow", 64'(readData), 64'h0);
    applyStimulus(1'b1, 1'b0, MTIME_ADDR + 32'd4, 32'h0, 4'h0);
    checkOutput("s4WrapHigh", 64'(readData), 64'h0);

    // Scenario 5: byte-lane write into mtimecmp[0] low, then read-during-write
    applyStimulus(1'b0, 1'b1, MTIMECMP_BASE, 32'h0000_AB00, 4'b0010);
    applyStimulus(1'b1, 1'b0, MTIMECMP_BASE, 32'h0, 4'h0);
    checkOutput("s5ByteLane", 64'(readData), 64'hFFFF_ABFF);
    applyStimulus(1'b1, 1'b1, MTIMECMP_BASE + 32'd4, 32'h1234_5678, 4'hF);
    checkOutput("s5ReadOldOnWrite", 64'(readData), 64'hFFFF_FFFF);
    applyStimulus(1'b1, 1'b0, MTIMECMP_BASE + 32'd4, 32'h0, 4'h0);
    checkOutput("s5ReadNew", 64'(readData), 64'h1234_5678);

    // Scenario 6: msip[1], unmapped holes, reset in the middle of a write
    applyStimulus(1'b0, 1'b1, MSIP_BASE + 32'd4, 32'hFFFF_FFFF, 4'hF);
    checkOutput("s6SoftIrq", 64'(softwareInterrupt), 64'b10);
    applyStimulus(1'b1, 1'b0, MSIP_BASE + 32'd4, 32'h0, 4'h0);
    checkOutput("s6MsipRead", 64'(readData), 64'h1);
    applyStimulus(1'b1, 1'b0, MSIP_BASE + 32'd8, 32'h0, 4'h0);
    checkOutput("s6UnmappedRead", 64'(readData), 64'h0);
    applyStimulus(1'b0, 1'b1, MSIP_BASE + 32'd8, 32'hFFFF_FFFF, 4'hF);
    checkOutput("s6UnmappedWrite", 64'(softwareInterrupt), 64'b10);
    applyStimulus(1'b1, 1'b0, MSIP_BASE + 32'd4, 32'h0, 4'h0);
    checkOutput("s6MsipReread", 64'(readData), 64'h1);

    writeEnable     = 1'b1;
    address         = MSIP_BASE;
    writeData       = 32'h1;
    writeByteEnable = 4'hF;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("s6AsyncSoftIrq", 64'(softwareInterrupt), 64'b00);
    checkOutput("s6AsyncReadData", 64'(readData), 64'h0);
    checkOutput("s6AsyncMtime", dut.mtime, 64'h0);
    @(posedge clock);
    #1;
    writeEnable     = 1'b0;
    address         = 32'h0;
    writeData       = 32'h0;
    writeByteEnable = 4'h0;
    checkOutput("s6WriteDiscarded", 64'(softwareInterrupt), 64'b00);
    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, MTIMECMP_BASE, 32'h0, 4'h0);
    checkOutput("s6CmpResetValue", 64'(readData), 64'hFFFF_FFFF);
    checkOutput("s6TimerAfterReset", 64'(timerInterrupt), 64'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
